// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, valid/ready holding register.
// Optional parity stage is compiled in when the macro UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int HALF     = BAUD_CNT / 2;
  localparam int CNT_W    = $clog2(BAUD_CNT);
  localparam int BIT_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] C_HM1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] C_HP1  = CNT_W'(HALF + 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1) || HALF < 2) begin : g_param_check
    $error("uart_rx_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_line_d;
  logic [CNT_W-1:0]       r_baud_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic                   r_stop_cnt;
  logic                   r_samp0;
  logic                   r_samp1;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_ferr;
  logic                   r_done;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_line;
  logic w_fall;
  logic w_last;
  logic w_dec;
  logic w_maj;
  logic w_final_stop;
  logic w_accept_new;

  assign w_line       = r_sync2;
  assign w_fall       = r_line_d & ~w_line;
  assign w_last       = (r_baud_cnt == C_LAST);
  assign w_dec        = (r_baud_cnt == C_HP1);
  assign w_maj        = (r_samp0 & r_samp1) | (r_samp0 & w_line) | (r_samp1 & w_line);
  assign w_final_stop = (STOP_BITS == 1) || r_stop_cnt;
  assign w_accept_new = ~r_rx_valid | rx_ready;

  // uart_rx is asynchronous; the third flop only provides the edge reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_line_d <= 1'b1;
    end else begin
      r_sync1  <= uart_rx;
      r_sync2  <= r_sync1;
      r_line_d <= w_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_dec && w_maj)  w_state_nxt = S_IDLE;
        else if (w_last)     w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_last && (r_bit_cnt == C_BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        if (w_last) w_state_nxt = S_STOP;
      end
      // The final stop bit releases at its decision point so a fast transmitter can follow immediately
      S_STOP: begin
        if (w_dec && w_final_stop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_samp0    <= 1'b1;
      r_samp1    <= 1'b1;
      r_shift    <= '0;
      r_ferr     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_state_nxt == S_IDLE || w_last) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end

      if (r_baud_cnt == C_HM1)  r_samp0 <= w_line;
      if (r_baud_cnt == C_HALF) r_samp1 <= w_line;

      if (r_state != S_DATA) begin
        r_bit_cnt <= '0;
      end else if (w_last) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (r_state == S_DATA && w_dec) r_shift[r_bit_cnt] <= w_maj;

      if (r_state != S_STOP) begin
        r_stop_cnt <= 1'b0;
      end else if (w_last) begin
        r_stop_cnt <= 1'b1;
      end

      if (r_state == S_IDLE) begin
        r_ferr <= 1'b0;
      end else if (r_state == S_STOP && w_dec && !w_maj) begin
        r_ferr <= 1'b1;
      end

      r_done <= (r_state == S_STOP) && w_dec && w_final_stop;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_perr;
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_perr <= 1'b0;
    end else if (r_state == S_PARITY && w_dec) begin
      r_perr <= w_maj ^ (^r_shift) ^ (PARITY_ODD != 0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (r_done && w_accept_new) begin
      r_parity_err <= r_perr;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // Completion cycle: load the holding register if it is free or being drained, else drop and flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (w_accept_new) begin
          r_rx_data   <= r_shift;
          r_frame_err <= r_ferr;
          r_rx_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed frames at a short bit period, checked against a queue model of completed frames.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int BCNT     = CLK_FREQ / BAUD;
  localparam int HALF     = BCNT / 2;
  localparam int SB       = 1;
  localparam int ODD      = 0;
`ifdef UART_RX_PARITY_EN
  localparam int DW       = 7;
  localparam bit PAR_EN   = 1'b1;
`else
  localparam int DW       = 8;
  localparam bit PAR_EN   = 1'b0;
`endif
  localparam int MASK     = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;
  logic          busy;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DW), .STOP_BITS(SB), .PARITY_ODD(ODD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          fe;
    logic          pe;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            n_deliv = 0;
  int            n_ovr = 0;
  int            cyc = 0;
  int            t_start = 0;
  int            t_acc = 0;
  logic [DW-1:0] last_data = '0;
  logic          last_fe = 1'b0;
  logic          last_pe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of frames completed on the wire; the front is the held word, an overrun drops the newest
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (q.size() == 0) begin
          chk("valid_without_frame", rx_valid, 1'b0);
        end else begin
          chk("rx_data", rx_data, q[0].d);
          chk("frame_err", frame_err, q[0].fe);
          chk("parity_err", parity_err, q[0].pe);
          if (rx_ready) begin
            last_data = rx_data;
            last_fe   = frame_err;
            last_pe   = parity_err;
            t_acc     = cyc;
            n_deliv++;
            void'(q.pop_front());
          end
        end
      end
      if (overrun_err) begin
        chk("overrun_needs_held_word", q.size() >= 2, 1'b1);
        if (q.size() >= 2) void'(q.pop_back());
        n_ovr++;
      end
    end
  end

  task automatic drive_bit(input logic v, input bit glitch);
    uart_rx = v;
    if (glitch) begin
      repeat (HALF + 1) @(posedge clk);
      #1 uart_rx = ~v;
      @(posedge clk);
      #1 uart_rx = v;
      repeat (BCNT - HALF - 2) @(posedge clk);
    end else begin
      repeat (BCNT) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop_val,
                            input int glitch_bit, input int gap);
    exp_t e;
    e.d  = d;
    e.fe = (stop_val == 1'b0);
    e.pe = PAR_EN & (pbit != ((^d) ^ (ODD != 0)));
    @(posedge clk);
    #1;
    t_start = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i], i == glitch_bit);
    if (PAR_EN) drive_bit(pbit, 1'b0);
    for (int s = 0; s < SB; s++) begin
      if (s == SB - 1) q.push_back(e);
      drive_bit(stop_val, 1'b0);
    end
    uart_rx = 1'b1;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_ok(input logic [DW-1:0] d);
    send_frame(d, (^d) ^ (ODD != 0), 1'b1, -1, 0);
  endtask

  task automatic wait_deliv(input int target, input string name);
    int t;
    t = 0;
    while (n_deliv < target && t < 4 * BCNT) begin
      @(posedge clk);
      t++;
    end
    chk(name, n_deliv, target);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run not finished after %0d ns", 600000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int o0;

    repeat (3) @(negedge clk);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun_err", overrun_err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);

    send_ok(DW'(8'hA5));
    wait_deliv(1, "basic_delivered");
    chk("basic_data", last_data, 32'hA5 & MASK);
    chk("basic_fe", last_fe, 0);
    chk("basic_latency", (t_acc - t_start >= 9 * BCNT + HALF) && (t_acc - t_start <= 10 * BCNT), 1);
    @(negedge clk);
    chk("basic_valid_one_cycle", rx_valid, 0);

    d0 = n_deliv;
    o0 = n_ovr;
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("false_start_busy_high", busy, 1);
    repeat (10) @(posedge clk);
    #1 chk("false_start_busy_low", busy, 0);
    repeat (2 * BCNT) @(posedge clk);
    #1 chk("false_start_no_delivery", n_deliv - d0, 0);
    chk("false_start_no_overrun", n_ovr - o0, 0);
    chk("false_start_valid", rx_valid, 0);

    send_frame(DW'(8'h3C), (^DW'(8'h3C)) ^ (ODD != 0), 1'b0, -1, 4);
    wait_deliv(2, "ferr_delivered");
    chk("ferr_data", last_data, 32'h3C & MASK);
    chk("ferr_flag", last_fe, 1);
    send_ok(DW'(8'h11));
    wait_deliv(3, "after_ferr_delivered");
    chk("after_ferr_data", last_data, 32'h11 & MASK);
    chk("after_ferr_flag", last_fe, 0);

    rx_ready = 1'b0;
    o0 = n_ovr;
    send_ok(DW'(8'h01));
    send_ok(DW'(8'h02));
    repeat (8) @(posedge clk);
    #1 chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_held", rx_data, 32'h01);
    chk("ovr_pulse_count", n_ovr - o0, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("ovr_valid_cleared", rx_valid, 0);
    chk("ovr_drained_word", last_data, 32'h01);
    chk("ovr_queue_empty", q.size(), 0);

    rx_ready = 1'b1;
    send_frame(DW'(8'h00), PAR_EN & (ODD != 0), 1'b1, 3, 0);
    wait_deliv(5, "glitch_delivered");
    chk("glitch_data", last_data, 0);

    d0 = n_deliv;
    @(posedge clk);
    #1;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    repeat (HALF) @(posedge clk);
    #2 rst_n = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    chk("midrst_rx_data", rx_data, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overrun_err", overrun_err, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3 * BCNT) @(posedge clk);
    #1 chk("midrst_no_delivery", n_deliv - d0, 0);
    chk("midrst_idle", busy, 0);

    send_ok(DW'(8'h5A));
    wait_deliv(d0 + 1, "post_rst_delivered");
    chk("post_rst_data", last_data, 32'h5A & MASK);

    if (PAR_EN) begin
      d0 = n_deliv;
      send_frame(DW'(8'h41), 1'b0, 1'b1, -1, 0);
      wait_deliv(d0 + 1, "par_good_delivered");
      chk("par_good_data", last_data, 32'h41);
      chk("par_good_flag", last_pe, 0);
      send_frame(DW'(8'h41), 1'b1, 1'b1, -1, 0);
      wait_deliv(d0 + 2, "par_bad_delivered");
      chk("par_bad_flag", last_pe, 1);
    end

    repeat (4) @(posedge clk);
    #1 chk("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
